asteroid_mover: RTL and testbench

Parametrised single-asteroid motion engine for the 160x120 playfield. Holds binary x/y coordinates, spawns at a configurable entry point, and steps in one of four directions at a programmable rate driven by the frame tick. It handles screen-edge exit or wrap-around and a hit-triggered explosion phase. The game controller instantiates one per asteroid lane; the renderer and collision checker consume its coordinates and status flags.

---
 rtl/asteroid_mover_if.sv | 32 +++
 rtl/asteroid_mover.sv | 170 +++++++++++++++++
 tb/tb_asteroid_mover.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/asteroid_mover_if.sv
`default_nettype none
// ============================================================================
//  Module      : asteroid_mover_if
//  Description : Control/status bundle between a lane controller and one
//                asteroid motion engine. Controller drives frame tick,
//                spawn and hit. Mover returns coordinates and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
interface asteroid_mover_if #(
    parameter int XW = 8,
    parameter int YW = 7
);
    logic          tick_i;
    logic          spawn_i;
    logic          hit_i;
    logic [XW-1:0] x_o;
    logic [YW-1:0] y_o;
    logic          active_o;
    logic          exploding_o;
    logic          exited_o;

    modport master (
        output tick_i, spawn_i, hit_i,
        input  x_o, y_o, active_o, exploding_o, exited_o
    );

    modport slave (
        input  tick_i, spawn_i, hit_i,
        output x_o, y_o, active_o, exploding_o, exited_o
    );
endinterface
`default_nettype wire

// File: rtl/asteroid_mover.sv
`default_nettype none
// ============================================================================
//  Module      : asteroid_mover
//  Description : Single-asteroid motion engine. Spawns at a fixed entry
//                point, steps along one axis at a tick-divided rate, and
//                either despawns or wraps at the screen edge. A hit starts
//                a timed explosion, after which the asteroid returns to idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module asteroid_mover #(
    parameter int X_MAX          = 159,
    parameter int Y_MAX          = 119,
    parameter int XW             = 8,
    parameter int YW             = 7,
    parameter int START_X        = 23,
    parameter int START_Y        = 119,
    parameter int DIR            = 3,
    parameter int STEP_PERIOD    = 1,
    parameter int STEP_SIZE      = 1,
    parameter int WRAP           = 0,
    parameter int EXPLODE_FRAMES = 8
) (
    input  wire logic            clock,
    input  wire logic            reset,
    asteroid_mover_if.slave      bus
);

    // Coordinate arithmetic runs one bit wider than the coordinate so the
    // edge compare never sees a modular wrap.
    localparam logic [XW:0] c_X_STEP  = (XW+1)'(STEP_SIZE);
    localparam logic [XW:0] c_X_MAX   = (XW+1)'(X_MAX);
    localparam logic [XW:0] c_X_SPAN  = (XW+1)'(X_MAX + 1);
    localparam logic [YW:0] c_Y_STEP  = (YW+1)'(STEP_SIZE);
    localparam logic [YW:0] c_Y_MAX   = (YW+1)'(Y_MAX);
    localparam logic [YW:0] c_Y_SPAN  = (YW+1)'(Y_MAX + 1);

    localparam logic [XW-1:0] c_START_X     = XW'(START_X);
    localparam logic [YW-1:0] c_START_Y     = YW'(START_Y);
    localparam logic [7:0]    c_PERIOD_LAST = 8'(STEP_PERIOD - 1);
    localparam logic [7:0]    c_EXPL_LAST   = 8'(EXPLODE_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE    = 2'd1,
        ST_EXPLODE = 2'd2
    } state_t;

    state_t        state_q;
    logic [7:0]    cnt_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic          active_q;
    logic          exploding_q;
    logic          exited_q;

    logic [XW:0]   x_inc;
    logic [XW:0]   x_ext;
    logic [YW:0]   y_inc;
    logic [YW:0]   y_ext;
    logic [XW:0]   x_d;
    logic [YW:0]   y_d;
    logic          oor_d;

    assign x_ext = {1'b0, x_q};
    assign y_ext = {1'b0, y_q};
    assign x_inc = x_ext + c_X_STEP;
    assign y_inc = y_ext + c_Y_STEP;

    // Candidate coordinates after one step on the configured axis, plus the
    // out-of-range flag that decides between step, wrap and despawn.
    always_comb begin
        x_d   = x_ext;
        y_d   = y_ext;
        oor_d = 1'b0;
        case (DIR)
            0: begin
                oor_d = (x_inc > c_X_MAX);
                x_d   = oor_d ? (x_inc - c_X_SPAN) : x_inc;
            end
            1: begin
                oor_d = (x_ext < c_X_STEP);
                x_d   = oor_d ? (x_ext + c_X_SPAN - c_X_STEP) : (x_ext - c_X_STEP);
            end
            2: begin
                oor_d = (y_inc > c_Y_MAX);
                y_d   = oor_d ? (y_inc - c_Y_SPAN) : y_inc;
            end
            default: begin
                oor_d = (y_ext < c_Y_STEP);
                y_d   = oor_d ? (y_ext + c_Y_SPAN - c_Y_STEP) : (y_ext - c_Y_STEP);
            end
        endcase
    end

    // Lifecycle FSM: owns state, shared counter, coordinates and all flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 8'd0;
            x_q         <= c_START_X;
            y_q         <= c_START_Y;
            active_q    <= 1'b0;
            exploding_q <= 1'b0;
            exited_q    <= 1'b0;
        end else begin
            exited_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.spawn_i) begin
                        state_q  <= ST_MOVE;
                        x_q      <= c_START_X;
                        y_q      <= c_START_Y;
                        cnt_q    <= 8'd0;
                        active_q <= 1'b1;
                    end
                end
                ST_MOVE: begin
                    if (bus.hit_i) begin
                        // Hit wins over a same-cycle tick; position freezes.
                        state_q     <= ST_EXPLODE;
                        cnt_q       <= c_EXPL_LAST;
                        active_q    <= 1'b0;
                        exploding_q <= 1'b1;
                    end else if (bus.tick_i) begin
                        if (cnt_q != c_PERIOD_LAST) begin
                            cnt_q <= cnt_q + 8'd1;
                        end else begin
                            cnt_q <= 8'd0;
                            if (oor_d && (WRAP == 0)) begin
                                state_q  <= ST_IDLE;
                                x_q      <= c_START_X;
                                y_q      <= c_START_Y;
                                active_q <= 1'b0;
                                exited_q <= 1'b1;
                            end else begin
                                x_q <= XW'(x_d);
                                y_q <= YW'(y_d);
                            end
                        end
                    end
                end
                ST_EXPLODE: begin
                    if (bus.tick_i) begin
                        if (cnt_q == 8'd0) begin
                            state_q     <= ST_IDLE;
                            x_q         <= c_START_X;
                            y_q         <= c_START_Y;
                            exploding_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 8'd1;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    active_q    <= 1'b0;
                    exploding_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.x_o         = x_q;
    assign bus.y_o         = y_q;
    assign bus.active_o    = active_q;
    assign bus.exploding_o = exploding_q;
    assign bus.exited_o    = exited_q;

endmodule
`default_nettype wire

// File: tb/tb_asteroid_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_asteroid_mover
//  Description : Self-checking bench for asteroid_mover. Five differently
//                configured movers run side by side against a behavioural
//                model; directed sequences pin known positions, then random
//                tick/spawn/hit traffic runs with per-cycle comparison.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_asteroid_mover;

    localparam int N = 5;
    localparam int P_IDLE = 0;
    localparam int P_MOVE = 1;
    localparam int P_BOOM = 2;

    typedef struct {
        int dir; int sx; int sy; int period; int step; int wrap; int ef;
    } cfg_t;

    typedef struct {
        int phase; int x; int y; int since; int left; bit exited;
    } mstate_t;

    logic       clock;
    logic       reset;
    logic [N-1:0] tk, sp, ht;
    logic [7:0] xs   [N];
    logic [6:0] ys   [N];
    logic       act  [N];
    logic       boom [N];
    logic       ext  [N];

    int  ntests = 0;
    int  nfail  = 0;
    bit  chk_en = 0;
    mstate_t m [N];

    asteroid_mover_if #(.XW(8), .YW(7)) if0 ();
    asteroid_mover_if #(.XW(8), .YW(7)) if1 ();
    asteroid_mover_if #(.XW(8), .YW(7)) if2 ();
    asteroid_mover_if #(.XW(8), .YW(7)) if3 ();
    asteroid_mover_if #(.XW(8), .YW(7)) if4 ();

    assign {if0.tick_i, if0.spawn_i, if0.hit_i} = {tk[0], sp[0], ht[0]};
    assign {if1.tick_i, if1.spawn_i, if1.hit_i} = {tk[1], sp[1], ht[1]};
    assign {if2.tick_i, if2.spawn_i, if2.hit_i} = {tk[2], sp[2], ht[2]};
    assign {if3.tick_i, if3.spawn_i, if3.hit_i} = {tk[3], sp[3], ht[3]};
    assign {if4.tick_i, if4.spawn_i, if4.hit_i} = {tk[4], sp[4], ht[4]};
    assign {xs[0], ys[0], act[0], boom[0], ext[0]} = {if0.x_o, if0.y_o, if0.active_o, if0.exploding_o, if0.exited_o};
    assign {xs[1], ys[1], act[1], boom[1], ext[1]} = {if1.x_o, if1.y_o, if1.active_o, if1.exploding_o, if1.exited_o};
    assign {xs[2], ys[2], act[2], boom[2], ext[2]} = {if2.x_o, if2.y_o, if2.active_o, if2.exploding_o, if2.exited_o};
    assign {xs[3], ys[3], act[3], boom[3], ext[3]} = {if3.x_o, if3.y_o, if3.active_o, if3.exploding_o, if3.exited_o};
    assign {xs[4], ys[4], act[4], boom[4], ext[4]} = {if4.x_o, if4.y_o, if4.active_o, if4.exploding_o, if4.exited_o};

    asteroid_mover u0 (.clock(clock), .reset(reset), .bus(if0));
    asteroid_mover #(.DIR(0), .START_X(158), .STEP_SIZE(2), .WRAP(1))
        u1 (.clock(clock), .reset(reset), .bus(if1));
    asteroid_mover #(.STEP_PERIOD(4), .EXPLODE_FRAMES(3))
        u2 (.clock(clock), .reset(reset), .bus(if2));
    asteroid_mover #(.DIR(1), .START_X(1), .STEP_SIZE(2), .WRAP(0))
        u3 (.clock(clock), .reset(reset), .bus(if3));
    asteroid_mover #(.DIR(1), .START_X(1), .STEP_SIZE(2), .WRAP(1))
        u4 (.clock(clock), .reset(reset), .bus(if4));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic cfg_t get_cfg(input int k);
        cfg_t c;
        c = '{dir: 3, sx: 23, sy: 119, period: 1, step: 1, wrap: 0, ef: 8};
        case (k)
            1: begin c.dir = 0; c.sx = 158; c.step = 2; c.wrap = 1; end
            2: begin c.period = 4; c.ef = 3; end
            3: begin c.dir = 1; c.sx = 1; c.step = 2; c.wrap = 0; end
            4: begin c.dir = 1; c.sx = 1; c.step = 2; c.wrap = 1; end
            default: ;
        endcase
        return c;
    endfunction

    function automatic mstate_t home(input cfg_t c);
        mstate_t s;
        s = '{phase: P_IDLE, x: c.sx, y: c.sy, since: 0, left: 0, exited: 1'b0};
        return s;
    endfunction

    // One frame of the rules: idle waits for spawn, move counts ticks and
    // steps/wraps/leaves, explosion counts down remaining ticks.
    function automatic mstate_t mstep(input cfg_t c, input mstate_t s, input bit t, input bit sn, input bit h);
        mstate_t n;
        int lim, cur, nc;
        n = s;
        n.exited = 1'b0;
        if (s.phase == P_IDLE) begin
            if (sn) begin
                n = home(c);
                n.phase = P_MOVE;
            end
        end else if (s.phase == P_MOVE) begin
            if (h) begin
                n.phase = P_BOOM;
                n.left  = c.ef;
            end else if (t) begin
                n.since = s.since + 1;
                if (n.since == c.period) begin
                    n.since = 0;
                    lim = (c.dir < 2) ? 159 : 119;
                    cur = (c.dir < 2) ? s.x : s.y;
                    nc  = (c.dir % 2 == 0) ? cur + c.step : cur - c.step;
                    if ((nc < 0 || nc > lim) && c.wrap == 0) begin
                        n = home(c);
                        n.exited = 1'b1;
                    end else begin
                        if (nc < 0)   nc = nc + lim + 1;
                        if (nc > lim) nc = nc - (lim + 1);
                        if (c.dir < 2) n.x = nc; else n.y = nc;
                    end
                end
            end
        end else begin
            if (t) begin
                n.left = s.left - 1;
                if (n.left == 0) n = home(c);
            end
        end
        return n;
    endfunction

    // Model advances on the same edges the DUT sees; reset is immediate.
    always @(posedge clock or posedge reset) begin
        for (int k = 0; k < N; k++) begin
            if (reset) m[k] = home(get_cfg(k));
            else       m[k] = mstep(get_cfg(k), m[k], tk[k], sp[k], ht[k]);
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        ntests++;
        if (actual != expected) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Per-cycle scoreboard on the falling edge.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("m%0d.x", k), int'(xs[k]), m[k].x);
                chk($sformatf("m%0d.y", k), int'(ys[k]), m[k].y);
                chk($sformatf("m%0d.active", k), int'(act[k]), int'(m[k].phase == P_MOVE));
                chk($sformatf("m%0d.exploding", k), int'(boom[k]), int'(m[k].phase == P_BOOM));
                chk($sformatf("m%0d.exited", k), int'(ext[k]), int'(m[k].exited));
            end
        end
    end

    task automatic go(input logic [N-1:0] t, input logic [N-1:0] s, input logic [N-1:0] h);
        tk = t; sp = s; ht = h;
        @(posedge clock);
        #1;
        tk = '0; sp = '0; ht = '0;
    endtask

    initial begin
        tk = '0; sp = '0; ht = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("reset.x0", int'(xs[0]), 23);
        chk("reset.y0", int'(ys[0]), 119);
        chk("reset.active0", int'(act[0]), 0);
        reset = 1'b0;
        chk_en = 1'b1;

        // Default lane: full descent then despawn at the bottom edge.
        go('0, 5'b00001, '0);
        chk("spawn.active0", int'(act[0]), 1);
        chk("spawn.y0", int'(ys[0]), 119);
        for (int k = 1; k <= 119; k++) begin
            go(5'b00001, '0, '0);
            chk("descend.y0", int'(ys[0]), 119 - k);
            chk("descend.x0", int'(xs[0]), 23);
        end
        go(5'b00001, '0, '0);
        chk("exit.exited0", int'(ext[0]), 1);
        chk("exit.active0", int'(act[0]), 0);
        chk("exit.y0", int'(ys[0]), 119);
        go('0, '0, '0);
        chk("exit.pulse_once0", int'(ext[0]), 0);

        // +x wrap with step 2 from x=158.
        go('0, 5'b00010, '0);
        go(5'b00010, '0, '0);
        chk("wrap.x1", int'(xs[1]), 0);
        chk("wrap.active1", int'(act[1]), 1);
        chk("wrap.exited1", int'(ext[1]), 0);
        go(5'b00010, '0, '0);
        chk("wrap2.x1", int'(xs[1]), 2);

        // Step period 4.
        go('0, 5'b00100, '0);
        for (int k = 1; k <= 12; k++) begin
            go(5'b00100, '0, '0);
            chk("period.y2", int'(ys[2]), 119 - k / 4);
        end

        // Spawn with tick and hit in the same cycle: only the spawn counts.
        go(5'b00001, 5'b00001, 5'b00001);
        chk("spawnmix.active0", int'(act[0]), 1);
        chk("spawnmix.exploding0", int'(boom[0]), 0);
        chk("spawnmix.y0", int'(ys[0]), 119);
        for (int k = 0; k < 5; k++) go(5'b00001, '0, '0);
        chk("pre_hit.y0", int'(ys[0]), 114);
        go(5'b00001, '0, 5'b00001);
        chk("hit.exploding0", int'(boom[0]), 1);
        chk("hit.active0", int'(act[0]), 0);
        chk("hit.y0", int'(ys[0]), 114);
        go('0, 5'b00001, '0);
        chk("boomspawn.exploding0", int'(boom[0]), 1);
        chk("boomspawn.active0", int'(act[0]), 0);
        for (int k = 0; k < 7; k++) go(5'b00001, '0, '0);
        chk("boom7.exploding0", int'(boom[0]), 1);
        chk("boom7.y0", int'(ys[0]), 114);
        go(5'b00001, '0, '0);
        chk("boom8.exploding0", int'(boom[0]), 0);
        chk("boom8.active0", int'(act[0]), 0);
        chk("boom8.y0", int'(ys[0]), 119);

        // -x edge from x=1 with step 2: despawn vs wrap.
        go('0, 5'b11000, '0);
        go(5'b11000, '0, '0);
        chk("minus.exited3", int'(ext[3]), 1);
        chk("minus.x3", int'(xs[3]), 1);
        chk("minus.active3", int'(act[3]), 0);
        chk("minus.x4", int'(xs[4]), 159);
        chk("minus.active4", int'(act[4]), 1);
        chk("minus.exited4", int'(ext[4]), 0);

        // Asynchronous reset while exploding.
        go('0, 5'b00001, '0);
        go(5'b00001, '0, '0);
        go('0, '0, 5'b00001);
        chk("prereset.exploding0", int'(boom[0]), 1);
        reset = 1'b1;
        #2;
        chk("areset.exploding0", int'(boom[0]), 0);
        chk("areset.active0", int'(act[0]), 0);
        chk("areset.x0", int'(xs[0]), 23);
        chk("areset.y0", int'(ys[0]), 119);
        @(posedge clock);
        #1;
        reset = 1'b0;
        go('0, 5'b00001, '0);
        chk("postreset.active0", int'(act[0]), 1);
        go(5'b00001, '0, '0);
        chk("postreset.y0", int'(ys[0]), 118);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] rt, rs, rh;
            for (int k = 0; k < N; k++) begin
                rt[k] = ($urandom_range(0, 1) == 0);
                rs[k] = ($urandom_range(0, 7) == 0);
                rh[k] = ($urandom_range(0, 31) == 0);
            end
            go(rt, rs, rh);
        end

        @(negedge clock);
        #1;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
`default_nettype wire
